// File: rtl/axi_rd_pkg.sv
// Shared AXI read constants and the per-slot bookkeeping record used by the burst master.
package axi_rd_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Bit positions inside the 2-bit completion error field {len_err, resp_err}
  localparam int ERR_RESP = 0;
  localparam int ERR_LEN  = 1;

  typedef struct packed {
    logic       busy;
    logic [7:0] len;
    logic [7:0] cnt;
    logic       resp_err;
    logic       len_err;
  } slot_t;

endpackage

// File: rtl/axi_rd_slot_table.sv
// Outstanding-burst table: lowest-free allocation, per-slot beat counting and error accumulation.
// Free mask and counts come from registered state only; a slot freed this cycle is allocatable next cycle.
module axi_rd_slot_table
  import axi_rd_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int TAG_W   = 8,
  parameter int IDX_W   = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             alloc_vld,
  input  logic [7:0]       alloc_len,
  input  logic [TAG_W-1:0] alloc_tag,
  output logic             free_any,
  output logic [IDX_W-1:0] free_idx,
  input  logic             beat_vld,
  input  logic [IDX_W-1:0] beat_idx,
  input  logic             beat_last,
  input  logic [1:0]       beat_resp,
  output logic             beat_ok,
  output logic [TAG_W-1:0] done_tag,
  output logic [1:0]       done_err,
  output logic [IDX_W:0]   busy_cnt
);

  slot_t [NUM_OUT-1:0]             slots;
  logic  [NUM_OUT-1:0][TAG_W-1:0]  tags;
  slot_t                           cur;
  logic                            resp_hit;
  logic                            len_hit;

  // Descending scan so the lowest free index wins
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    busy_cnt = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (!slots[i].busy) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end else begin
        busy_cnt = busy_cnt + (IDX_W + 1)'(1);
      end
    end
  end

  always_comb begin
    cur      = slots[beat_idx];
    beat_ok  = beat_vld && cur.busy;
    resp_hit = beat_resp inside {RESP_EXOKAY, RESP_SLVERR, RESP_DECERR};
    // cnt is the index of the beat arriving now; the final beat must carry rlast
    len_hit  = beat_last ? (cur.cnt != cur.len) : (cur.cnt == cur.len);
    done_tag = tags[beat_idx];
    done_err = '0;
    done_err[ERR_LEN]  = cur.len_err  | len_hit;
    done_err[ERR_RESP] = cur.resp_err | resp_hit;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slots <= '0;
      tags  <= '0;
    end else begin
      if (alloc_vld) begin
        slots[free_idx] <= '{busy: 1'b1, len: alloc_len, cnt: 8'd0, resp_err: 1'b0, len_err: 1'b0};
        tags[free_idx]  <= alloc_tag;
      end
      if (beat_ok) begin
        slots[beat_idx].cnt      <= cur.cnt + 8'd1;
        slots[beat_idx].resp_err <= done_err[ERR_RESP];
        slots[beat_idx].len_err  <= done_err[ERR_LEN];
        if (beat_last) begin
          slots[beat_idx].busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: commands become INCR bursts tagged by slot ID, responses are checked and forwarded.
// Latency 1 from cmd to AR and from R beat to output/done; rready drops only while the output stage is stalled.
module axi_rd_burst_master
  import axi_rd_pkg::*;
#(
  parameter int  DATA_W  = 256,
  parameter int  ADDR_W  = 32,
  parameter int  ID_W    = 7,
  parameter int  NUM_OUT = 4,
  parameter int  TAG_W   = 8,
  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [7:0]        i_cmd_len,
  input  logic [TAG_W-1:0]  i_cmd_tag,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [IDX_W-1:0]  o_rd_id,
  output logic              o_rd_last,
  output logic              o_done_valid,
  output logic [IDX_W-1:0]  o_done_id,
  output logic [TAG_W-1:0]  o_done_tag,
  output logic [1:0]        o_done_err,
  output logic              o_cmd_err,
  output logic              o_proto_err,
  output logic [IDX_W:0]    o_outstanding,
  output logic [31:0]       o_beat_cnt
);

  localparam int SIZE = $clog2(DATA_W / 8);

  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic             cmd_fire;
  logic             cmd_cross;
  logic             alloc_vld;
  logic [31:0]      cmd_end;
  logic             r_fire;
  logic             rid_in_range;
  logic             beat_ok;
  logic [TAG_W-1:0] done_tag;
  logic [1:0]       done_err;

  assign o_cmd_ready  = free_any && (!arvalid || arready);
  assign cmd_fire     = i_cmd_valid && o_cmd_ready;
  // One byte past the burst, measured from the start of its 4 KB page
  assign cmd_end      = 32'(i_cmd_addr[11:0]) + ((32'(i_cmd_len) + 32'd1) << SIZE);
  assign cmd_cross    = cmd_end > 32'd4096;
  assign alloc_vld    = cmd_fire && !cmd_cross;

  assign rready       = !o_rd_valid || i_rd_ready;
  assign r_fire       = rvalid && rready;
  assign rid_in_range = 32'(rid) < 32'(NUM_OUT);

  axi_rd_slot_table #(
    .NUM_OUT (NUM_OUT),
    .TAG_W   (TAG_W),
    .IDX_W   (IDX_W)
  ) u_slots (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .alloc_vld (alloc_vld),
    .alloc_len (i_cmd_len),
    .alloc_tag (i_cmd_tag),
    .free_any  (free_any),
    .free_idx  (free_idx),
    .beat_vld  (r_fire && rid_in_range),
    .beat_idx  (rid[IDX_W-1:0]),
    .beat_last (rlast),
    .beat_resp (rresp),
    .beat_ok   (beat_ok),
    .done_tag  (done_tag),
    .done_err  (done_err),
    .busy_cnt  (o_outstanding)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
      arburst <= '0;
    end else if (alloc_vld) begin
      arvalid <= 1'b1;
      arid    <= ID_W'(free_idx);
      araddr  <= i_cmd_addr;
      arlen   <= i_cmd_len;
      arsize  <= 3'(SIZE);
      arburst <= BURST_INCR;
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_valid   <= 1'b0;
      o_rd_data    <= '0;
      o_rd_id      <= '0;
      o_rd_last    <= 1'b0;
      o_done_valid <= 1'b0;
      o_done_id    <= '0;
      o_done_tag   <= '0;
      o_done_err   <= '0;
      o_cmd_err    <= 1'b0;
      o_proto_err  <= 1'b0;
      o_beat_cnt   <= '0;
    end else begin
      if (beat_ok) begin
        o_rd_valid <= 1'b1;
        o_rd_data  <= rdata;
        o_rd_id    <= rid[IDX_W-1:0];
        o_rd_last  <= rlast;
        o_beat_cnt <= o_beat_cnt + 32'd1;
      end else if (i_rd_ready) begin
        o_rd_valid <= 1'b0;
      end
      o_done_valid <= beat_ok && rlast;
      if (beat_ok && rlast) begin
        o_done_id  <= rid[IDX_W-1:0];
        o_done_tag <= done_tag;
        o_done_err <= done_err;
      end
      o_cmd_err   <= cmd_fire && cmd_cross;
      o_proto_err <= o_proto_err | (r_fire && !beat_ok);
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Directed bench for axi_rd_burst_master: hand-computed bursts, ordering, errors, backpressure and reset.
module tb_axi_rd_burst_master;
  import axi_rd_pkg::*;

  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int ID_W    = 7;
  localparam int NUM_OUT = 4;
  localparam int TAG_W   = 8;
  localparam int IDX_W   = 2;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [7:0]        i_cmd_len;
  logic [TAG_W-1:0]  i_cmd_tag;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              o_rd_valid;
  logic              i_rd_ready;
  logic [DATA_W-1:0] o_rd_data;
  logic [IDX_W-1:0]  o_rd_id;
  logic              o_rd_last;
  logic              o_done_valid;
  logic [IDX_W-1:0]  o_done_id;
  logic [TAG_W-1:0]  o_done_tag;
  logic [1:0]        o_done_err;
  logic              o_cmd_err;
  logic              o_proto_err;
  logic [IDX_W:0]    o_outstanding;
  logic [31:0]       o_beat_cnt;

  always #5 i_clk = ~i_clk;

  axi_rd_burst_master #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .ID_W (ID_W), .NUM_OUT (NUM_OUT), .TAG_W (TAG_W)
  ) dut (
    .i_clk (i_clk), .i_reset (i_reset),
    .i_cmd_valid (i_cmd_valid), .o_cmd_ready (o_cmd_ready),
    .i_cmd_addr (i_cmd_addr), .i_cmd_len (i_cmd_len), .i_cmd_tag (i_cmd_tag),
    .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize),
    .arburst (arburst), .arvalid (arvalid), .arready (arready),
    .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready),
    .o_rd_valid (o_rd_valid), .i_rd_ready (i_rd_ready), .o_rd_data (o_rd_data),
    .o_rd_id (o_rd_id), .o_rd_last (o_rd_last),
    .o_done_valid (o_done_valid), .o_done_id (o_done_id), .o_done_tag (o_done_tag),
    .o_done_err (o_done_err), .o_cmd_err (o_cmd_err), .o_proto_err (o_proto_err),
    .o_outstanding (o_outstanding), .o_beat_cnt (o_beat_cnt)
  );

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  id;
    logic              last;
  } beat_t;
  typedef struct packed {
    logic [IDX_W-1:0] id;
    logic [TAG_W-1:0] tag;
    logic [1:0]       err;
  } done_t;

  ar_t   ar_q[$];
  beat_t out_q[$];
  done_t done_q[$];
  int    cmd_err_seen;
  int    exp_beats;
  int    tests = 0;
  int    fails = 0;

  logic [3:0]       t1_nib  [6] = '{4'hC, 4'hB, 4'hA, 4'h1, 4'hF, 4'hE};
  logic [IDX_W-1:0] t2_ids  [5] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
  logic [TAG_W-1:0] t2_tags [5] = '{8'h23, 8'h21, 8'h20, 8'h22, 8'h24};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [3:0] n);
    return {64{n}};
  endfunction

  function automatic ar_t pop_ar();
    if (ar_q.size() == 0) return '0;
    return ar_q.pop_front();
  endfunction

  function automatic beat_t pop_beat();
    if (out_q.size() == 0) return '0;
    return out_q.pop_front();
  endfunction

  function automatic done_t pop_done();
    if (done_q.size() == 0) return '0;
    return done_q.pop_front();
  endfunction

  // Handshakes seen here complete at the following rising edge
  always @(negedge i_clk) begin
    #2;
    if (arvalid && arready) ar_q.push_back({arid, araddr, arlen, arsize, arburst});
    if (o_rd_valid && i_rd_ready) out_q.push_back({o_rd_data, o_rd_id, o_rd_last});
    if (o_done_valid) done_q.push_back({o_done_id, o_done_tag, o_done_err});
    if (o_cmd_err) cmd_err_seen++;
  end

  // Tasks below start and end on a falling edge
  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [7:0] t);
    logic rdy;
    int   n;
    i_cmd_valid = 1'b1;
    i_cmd_addr  = a;
    i_cmd_len   = l;
    i_cmd_tag   = t;
    n = 0;
    forever begin
      #1 rdy = o_cmd_ready;
      @(negedge i_clk);
      if (rdy) break;
      n++;
      if (n > 300) begin
        check("cmd_timeout", 256'(rdy), 256'(1));
        break;
      end
    end
    i_cmd_valid = 1'b0;
  endtask

  task automatic r_beat(input logic [6:0] id, input logic [DATA_W-1:0] d,
                        input logic [1:0] resp, input logic last);
    logic rdy;
    int   n;
    rvalid = 1'b1;
    rid    = id;
    rdata  = d;
    rresp  = resp;
    rlast  = last;
    n = 0;
    forever begin
      #1 rdy = rready;
      @(negedge i_clk);
      if (rdy) break;
      n++;
      if (n > 300) begin
        check("rbeat_timeout", 256'(rdy), 256'(1));
        break;
      end
    end
    rvalid = 1'b0;
  endtask

  task automatic burst(input logic [6:0] id, input int n, input logic [3:0] base);
    for (int i = 0; i < n; i++) r_beat(id, pat(base + 4'(i)), RESP_OKAY, i == n - 1);
    exp_beats += n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ar_t   a;
    beat_t b;
    done_t d;
    int    ce0;

    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0; i_cmd_tag = '0;
    arready = 1'b1; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    i_rd_ready = 1'b1; exp_beats = 0; cmd_err_seen = 0;
    repeat (3) @(negedge i_clk);

    check("rst_arvalid", 256'(arvalid), 256'(0));
    check("rst_araddr", 256'(araddr), 256'(0));
    check("rst_rd_valid", 256'(o_rd_valid), 256'(0));
    check("rst_done_valid", 256'(o_done_valid), 256'(0));
    check("rst_cmd_err", 256'(o_cmd_err), 256'(0));
    check("rst_proto_err", 256'(o_proto_err), 256'(0));
    check("rst_outstanding", 256'(o_outstanding), 256'(0));
    check("rst_beat_cnt", 256'(o_beat_cnt), 256'(0));
    check("rst_cmd_ready", 256'(o_cmd_ready), 256'(1));
    check("rst_rready", 256'(rready), 256'(1));
    i_reset = 1'b0;
    @(negedge i_clk);

    // Single 6-beat burst
    send_cmd(32'h0, 8'd5, 8'h11);
    @(negedge i_clk);
    check("t1_ar_cnt", 256'(ar_q.size()), 256'(1));
    a = pop_ar();
    check("t1_arid", 256'(a.id), 256'(0));
    check("t1_araddr", 256'(a.addr), 256'(0));
    check("t1_arlen", 256'(a.len), 256'(5));
    check("t1_arsize", 256'(a.size), 256'(5));
    check("t1_arburst", 256'(a.burst), 256'(1));
    check("t1_outstanding", 256'(o_outstanding), 256'(1));
    r_beat(7'd0, pat(t1_nib[0]), RESP_OKAY, 1'b0);
    check("t1_lat_valid", 256'(o_rd_valid), 256'(1));
    check("t1_lat_data", o_rd_data, pat(4'hC));
    for (int i = 1; i < 6; i++) r_beat(7'd0, pat(t1_nib[i]), RESP_OKAY, i == 5);
    check("t1_done_lat", 256'(o_done_valid), 256'(1));
    exp_beats += 6;
    repeat (2) @(negedge i_clk);
    check("t1_beats", 256'(out_q.size()), 256'(6));
    for (int i = 0; i < 6; i++) begin
      b = pop_beat();
      check($sformatf("t1_data%0d", i), b.data, pat(t1_nib[i]));
      check($sformatf("t1_last%0d", i), 256'(b.last), 256'(i == 5));
    end
    check("t1_done_cnt", 256'(done_q.size()), 256'(1));
    d = pop_done();
    check("t1_done_id", 256'(d.id), 256'(0));
    check("t1_done_tag", 256'(d.tag), 256'(8'h11));
    check("t1_done_err", 256'(d.err), 256'(0));
    check("t1_outstanding_end", 256'(o_outstanding), 256'(0));
    check("t1_beat_cnt", 256'(o_beat_cnt), 256'(exp_beats));

    // Four outstanding bursts, completed out of order, fifth stalls
    ar_q.delete(); out_q.delete(); done_q.delete();
    send_cmd(32'h000, 8'd5, 8'h20);
    send_cmd(32'h100, 8'd5, 8'h21);
    send_cmd(32'h200, 8'd3, 8'h22);
    send_cmd(32'h300, 8'd1, 8'h23);
    check("t2_outstanding4", 256'(o_outstanding), 256'(4));
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h400; i_cmd_len = 8'd0; i_cmd_tag = 8'h24;
    #1 check("t2_stall0", 256'(o_cmd_ready), 256'(0));
    repeat (2) @(negedge i_clk);
    #1 check("t2_stall2", 256'(o_cmd_ready), 256'(0));
    @(negedge i_clk);
    check("t2_ar_cnt", 256'(ar_q.size()), 256'(4));
    for (int i = 0; i < 4; i++) begin
      a = pop_ar();
      check($sformatf("t2_arid%0d", i), 256'(a.id), 256'(i));
      check($sformatf("t2_araddr%0d", i), 256'(a.addr), 256'(i * 256));
    end
    fork
      send_cmd(32'h400, 8'd0, 8'h24);
      begin
        burst(7'd3, 2, 4'h0);
        burst(7'd1, 6, 4'h0);
        burst(7'd0, 6, 4'h0);
        burst(7'd2, 4, 4'h0);
      end
    join
    repeat (2) @(negedge i_clk);
    check("t2_ar5_cnt", 256'(ar_q.size()), 256'(1));
    a = pop_ar();
    check("t2_ar5_id", 256'(a.id), 256'(3));
    check("t2_ar5_addr", 256'(a.addr), 256'(32'h400));
    burst(7'd3, 1, 4'h9);
    repeat (2) @(negedge i_clk);
    check("t2_done_cnt", 256'(done_q.size()), 256'(5));
    for (int i = 0; i < 5; i++) begin
      d = pop_done();
      check($sformatf("t2_done_id%0d", i), 256'(d.id), 256'(t2_ids[i]));
      check($sformatf("t2_done_tag%0d", i), 256'(d.tag), 256'(t2_tags[i]));
    end
    check("t2_beats", 256'(out_q.size()), 256'(19));
    check("t2_outstanding0", 256'(o_outstanding), 256'(0));

    // Output backpressure toggling during an 8-beat burst
    out_q.delete(); done_q.delete();
    send_cmd(32'h800, 8'd7, 8'h30);
    fork
      for (int i = 0; i < 8; i++) r_beat(7'd0, pat(4'(i + 1)), RESP_OKAY, i == 7);
      repeat (24) begin
        @(negedge i_clk);
        i_rd_ready = ~i_rd_ready;
      end
    join
    i_rd_ready = 1'b1;
    exp_beats += 8;
    repeat (3) @(negedge i_clk);
    check("t3_beats", 256'(out_q.size()), 256'(8));
    for (int i = 0; i < 8; i++) begin
      b = pop_beat();
      check($sformatf("t3_data%0d", i), b.data, pat(4'(i + 1)));
      check($sformatf("t3_last%0d", i), 256'(b.last), 256'(i == 7));
    end
    check("t3_beat_cnt", 256'(o_beat_cnt), 256'(exp_beats));
    d = pop_done();
    check("t3_done_tag", 256'(d.tag), 256'(8'h30));

    // Early rlast and SLVERR
    done_q.delete();
    send_cmd(32'h0, 8'd5, 8'h40);
    r_beat(7'd0, pat(4'h1), RESP_OKAY, 1'b0);
    r_beat(7'd0, pat(4'h2), RESP_OKAY, 1'b0);
    r_beat(7'd0, pat(4'h3), RESP_OKAY, 1'b1);
    exp_beats += 3;
    @(negedge i_clk);
    d = pop_done();
    check("t4_len_tag", 256'(d.tag), 256'(8'h40));
    check("t4_len_err", 256'(d.err), 256'(2'b10));
    check("t4_len_freed", 256'(o_outstanding), 256'(0));
    send_cmd(32'h40, 8'd1, 8'h41);
    r_beat(7'd0, pat(4'h4), RESP_SLVERR, 1'b0);
    r_beat(7'd0, pat(4'h5), RESP_OKAY, 1'b1);
    exp_beats += 2;
    @(negedge i_clk);
    d = pop_done();
    check("t4_resp_tag", 256'(d.tag), 256'(8'h41));
    check("t4_resp_err", 256'(d.err), 256'(2'b01));

    // 4 KB crossing, exact-fit boundary, and unallocated RID
    ar_q.delete(); done_q.delete();
    ce0 = cmd_err_seen;
    send_cmd(32'hFE0, 8'd1, 8'h50);
    repeat (2) @(negedge i_clk);
    check("t5_cmd_err", 256'(cmd_err_seen), 256'(ce0 + 1));
    check("t5_cmd_err_pulse", 256'(o_cmd_err), 256'(0));
    check("t5_no_ar", 256'(ar_q.size()), 256'(0));
    check("t5_no_alloc", 256'(o_outstanding), 256'(0));
    send_cmd(32'hFC0, 8'd1, 8'h51);
    repeat (2) @(negedge i_clk);
    check("t5_fit_no_err", 256'(cmd_err_seen), 256'(ce0 + 1));
    a = pop_ar();
    check("t5_fit_addr", 256'(a.addr), 256'(32'hFC0));
    burst(7'd0, 2, 4'h6);
    @(negedge i_clk);
    d = pop_done();
    check("t5_fit_tag", 256'(d.tag), 256'(8'h51));
    check("t5_proto_before", 256'(o_proto_err), 256'(0));
    r_beat(7'd5, pat(4'h9), RESP_OKAY, 1'b1);
    @(negedge i_clk);
    check("t5_proto_set", 256'(o_proto_err), 256'(1));
    check("t5_proto_no_count", 256'(o_beat_cnt), 256'(exp_beats));
    check("t5_proto_no_done", 256'(done_q.size()), 256'(0));

    // Reset in the middle of a burst
    send_cmd(32'h0, 8'd0, 8'h60);
    send_cmd(32'h100, 8'd5, 8'h61);
    r_beat(7'd1, pat(4'h1), RESP_OKAY, 1'b0);
    r_beat(7'd1, pat(4'h2), RESP_OKAY, 1'b0);
    r_beat(7'd1, pat(4'h3), RESP_OKAY, 1'b0);
    i_reset = 1'b1;
    #1;
    check("t6_outstanding", 256'(o_outstanding), 256'(0));
    check("t6_rd_valid", 256'(o_rd_valid), 256'(0));
    check("t6_arvalid", 256'(arvalid), 256'(0));
    check("t6_proto_err", 256'(o_proto_err), 256'(0));
    check("t6_beat_cnt", 256'(o_beat_cnt), 256'(0));
    check("t6_rd_data", o_rd_data, 256'(0));
    @(negedge i_clk);
    i_reset = 1'b0;
    ar_q.delete(); out_q.delete(); done_q.delete();
    exp_beats = 0;
    @(negedge i_clk);
    send_cmd(32'h200, 8'd1, 8'h62);
    @(negedge i_clk);
    a = pop_ar();
    check("t6_new_slot", 256'(a.id), 256'(0));
    check("t6_new_outstanding", 256'(o_outstanding), 256'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_rd_burst_master.md
# axi_rd_burst_master

Parametrised, synthesizable AXI4 read master that replaces the behavioural read generator used to read back assembled payload from the assembly SRAM. It accepts read commands on a valid/ready port and issues INCR bursts with up to NUM_OUT outstanding, each tagged with a distinct ARID. It checks each response burst for RLAST/length and RRESP errors and forwards beats on a registered output stream. Sits between the verification/DMA control logic and the SRAM AXI slave port.

## Interface
- DATA_W, 256, AXI data width in bits (power of 2, ≥ 32)
- ADDR_W, 32, address width
- ID_W, 7, AXI ID width
- NUM_OUT, 4, max outstanding bursts (power of 2, ≤ 2^ID_W)
- TAG_W, 8, user tag carried from command to completion

- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake
- i_cmd_addr  in  ADDR_W  burst start address (DATA_W/8 aligned)
- i_cmd_len  in  8  beats−1
- i_cmd_tag  in  TAG_W  user tag
- arid, araddr, arlen, arsize, arburst, arvalid  out  ID_W/ADDR_W/8/3/2/1  AXI AR channel
- arready  in  1
- rid, rdata, rresp, rlast, rvalid  in  ID_W/DATA_W/2/1/1  AXI R channel
- rready  out  1
- o_rd_valid / i_rd_ready  out/in  1  output beat handshake
- o_rd_data  out  DATA_W; o_rd_id  out  log2(NUM_OUT); o_rd_last  out  1
- o_done_valid  out  1  one-cycle completion pulse, no backpressure
- o_done_id  out  log2(NUM_OUT); o_done_tag  out  TAG_W; o_done_err  out  2  {len_err, resp_err}
- o_cmd_err  out  1  one-cycle pulse: command dropped (4 KB crossing)
- o_proto_err  out  1  sticky: beat with unallocated RID
- o_outstanding  out  log2(NUM_OUT)+1  allocated slots
- o_beat_cnt  out  32  total accepted R beats, wraps

## Operation
- Slot table, NUM_OUT entries: busy, len, beat count, tag, resp_err, len_err.
- o_cmd_ready = any slot free && (!arvalid || arready). On accept, lowest-index free slot is allocated; AR registered: arid = slot index zero-extended, araddr = i_cmd_addr, arlen = i_cmd_len, arsize = log2(DATA_W/8), arburst = 2'b01.
- 4 KB check: if addr[11:0] + (len+1)·DATA_W/8 > 4096, command is accepted (ready honoured), not allocated, no AR; o_cmd_err pulses.
- arvalid is held with stable fields until arready.
- rready = !o_rd_valid || i_rd_ready.
- R beat accepted with rid ≥ NUM_OUT or slot not busy: beat dropped, o_proto_err set, no count change.
- Valid beat: registered to output stage; slot count +1; rresp ≠ 0 sets resp_err; rlast with count ≠ len, or count == len without rlast, sets len_err.
- Beat with rlast: slot freed; o_done_valid pulses with id, tag, and accumulated err bits including those from this beat; o_rd_last = rlast.
- Slot freed and command arriving in the same cycle: freed slot is not allocatable until next cycle (free mask from registered state).
- Out-of-order completion across IDs supported; within one ID beats are in order.

## Timing
- Reset: arvalid, rready-gating state, o_rd_valid, o_done_valid, o_cmd_err, o_proto_err = 0; all slots free; counters 0; ar*/o_rd_data fields 0.
- Command accepted at edge N → arvalid high from N+1. Back-to-back ARs at one per cycle while arready is high.
- R beat at edge M → o_rd_valid and (if last) o_done_valid from M+1. Latency 1; full throughput with i_rd_ready high.
- Reset mid-operation clears all state immediately; AXI slave must be reset together with this block.

## Structure
- Package axi_rd_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR, error-bit indices, slot record typedef.
- Sub-module axi_rd_slot_table: allocation (priority encoder), per-slot counters, error accumulation, free-on-last.

## Test plan
- Cmd addr 0x0, len 5, tag 0x11; slave returns CCCC…, BBBB…, AAAA…, 1111…, FFFF…, EEEE… → 6 output beats in order, last on beat 5, done id 0 tag 0x11 err 00.
- Four cmds to 0x0/0x100/0x200/0x300 (len 5/5/3/1); slave returns ID 3, 1, 0, 2 → all four done pulses, o_outstanding 4 → 0, fifth cmd stalls until first free.
- i_rd_ready toggled 1-0 every cycle during 8-beat burst → rready follows stage state, no beat lost or duplicated, o_beat_cnt +8.
- RLAST on beat 2 of len 5 → done err 10, slot freed; SLVERR on one beat → err 01.
- Cmd addr 0xFE0, len 1 (DATA_W 256) → o_cmd_err pulse, no AR; rid 5 with NUM_OUT 4 → o_proto_err set.
- Reset asserted mid-burst at beat 3 → all outputs 0 next cycle, o_outstanding 0, next cmd gets slot 0.
